id_ex_stage_latch: RTL and testbench

//  ID/EX pipeline register directly downstream of the hazard control mux. Captures the
//  (possibly zeroed) control bundle and the decode-stage datapath fields, and presents them to EX.

---
 rtl/id_ex_pkg.sv | 107 ++++++++++
 rtl/id_ex_stage_latch_sat_counter.sv | 29 ++
 rtl/id_ex_stage_latch.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage_latch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// id_ex_pkg
//   Shared definitions for the ID/EX pipeline boundary: the packed control
//   bundle width, the bit position of every control field, a structured
//   view of the bundle, and pack/unpack helpers used by the hazard mux,
//   this latch and the EX stage so that all three agree on one layout.
//   Also holds the per-edge action encoding used inside the latch.
package id_ex_pkg;

  localparam int NB_CTRL = 21;

  // Control bundle bit positions, LSB first.
  localparam int CTRL_REG_DST_RD     = 0;
  localparam int CTRL_JUMP           = 1;
  localparam int CTRL_JAL            = 2;
  localparam int CTRL_BRANCH         = 3;
  localparam int CTRL_NEQ_BRANCH     = 4;
  localparam int CTRL_MEM_READ       = 5;
  localparam int CTRL_MEM_TO_REG     = 6;
  localparam int CTRL_ALU_OP_LO      = 7;
  localparam int CTRL_ALU_OP_HI      = 8;
  localparam int CTRL_MEM_WRITE      = 9;
  localparam int CTRL_ALU_SRC        = 10;
  localparam int CTRL_REG_WRITE      = 11;
  localparam int CTRL_EXT_MODE_LO    = 12;
  localparam int CTRL_EXT_MODE_HI    = 13;
  localparam int CTRL_DATAMEM_LO     = 14;
  localparam int CTRL_DATAMEM_HI     = 15;
  localparam int CTRL_SIZE_FILT_LO   = 16;
  localparam int CTRL_SIZE_FILT_HI   = 17;
  localparam int CTRL_ZERO_EXTEND    = 18;
  localparam int CTRL_LUI            = 19;
  localparam int CTRL_JALR           = 20;

  typedef struct packed {
    logic       jal_r;
    logic       lui;
    logic       zero_extend;
    logic [1:0] size_filter_l;
    logic [1:0] datamem_size;
    logic [1:0] ext_mode;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       mem_read;
    logic       neq_branch;
    logic       branch;
    logic       jal;
    logic       jump;
    logic       reg_dst_rd;
  } ctrl_t;

  // What the latch does on a given edge (reset handled separately).
  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_STALL  = 2'd1,
    OP_FLUSH  = 2'd2,
    OP_FREEZE = 2'd3
  } latch_op_t;

  function automatic logic [NB_CTRL-1:0] pack_ctrl(input ctrl_t c);
    logic [NB_CTRL-1:0] v;
    v = '0;
    v[CTRL_REG_DST_RD]                    = c.reg_dst_rd;
    v[CTRL_JUMP]                          = c.jump;
    v[CTRL_JAL]                           = c.jal;
    v[CTRL_BRANCH]                        = c.branch;
    v[CTRL_NEQ_BRANCH]                    = c.neq_branch;
    v[CTRL_MEM_READ]                      = c.mem_read;
    v[CTRL_MEM_TO_REG]                    = c.mem_to_reg;
    v[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]      = c.alu_op;
    v[CTRL_MEM_WRITE]                     = c.mem_write;
    v[CTRL_ALU_SRC]                       = c.alu_src;
    v[CTRL_REG_WRITE]                     = c.reg_write;
    v[CTRL_EXT_MODE_HI:CTRL_EXT_MODE_LO]  = c.ext_mode;
    v[CTRL_DATAMEM_HI:CTRL_DATAMEM_LO]    = c.datamem_size;
    v[CTRL_SIZE_FILT_HI:CTRL_SIZE_FILT_LO] = c.size_filter_l;
    v[CTRL_ZERO_EXTEND]                   = c.zero_extend;
    v[CTRL_LUI]                           = c.lui;
    v[CTRL_JALR]                          = c.jal_r;
    return v;
  endfunction

  function automatic ctrl_t unpack_ctrl(input logic [NB_CTRL-1:0] v);
    ctrl_t c;
    c.reg_dst_rd    = v[CTRL_REG_DST_RD];
    c.jump          = v[CTRL_JUMP];
    c.jal           = v[CTRL_JAL];
    c.branch        = v[CTRL_BRANCH];
    c.neq_branch    = v[CTRL_NEQ_BRANCH];
    c.mem_read      = v[CTRL_MEM_READ];
    c.mem_to_reg    = v[CTRL_MEM_TO_REG];
    c.alu_op        = v[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO];
    c.mem_write     = v[CTRL_MEM_WRITE];
    c.alu_src       = v[CTRL_ALU_SRC];
    c.reg_write     = v[CTRL_REG_WRITE];
    c.ext_mode      = v[CTRL_EXT_MODE_HI:CTRL_EXT_MODE_LO];
    c.datamem_size  = v[CTRL_DATAMEM_HI:CTRL_DATAMEM_LO];
    c.size_filter_l = v[CTRL_SIZE_FILT_HI:CTRL_SIZE_FILT_LO];
    c.zero_extend   = v[CTRL_ZERO_EXTEND];
    c.lui           = v[CTRL_LUI];
    c.jal_r         = v[CTRL_JALR];
    return c;
  endfunction

endpackage

// File: rtl/id_ex_stage_latch_sat_counter.sv
// sat_counter
//   Up-counter that stops at its all-ones value instead of wrapping.
//   Ports:
//     clk     in   1       clock
//     rst_n   in   1       synchronous active-low reset (clears count)
//     enable  in   1       0 holds the count regardless of inc
//     inc     in   1       request +1 this edge (when enabled)
//     count   out  NB_CNT  current count
module sat_counter #(
  parameter int NB_CNT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              inc,
  output logic [NB_CNT-1:0] count
);

  localparam logic [NB_CNT-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable && inc && (count != CNT_MAX)) begin
      count <= count + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage_latch.sv
// id_ex_stage_latch
//   ID/EX pipeline register sitting after the hazard control mux. Registers
//   the control bundle and decode datapath fields for EX, with debug freeze,
//   flush (branch/jump taken) and stall bubble insertion, a sticky halt flag
//   and a saturating bubble counter read by the debug unit.
//   Ports:
//     i_clk, i_rst_n        clock, synchronous active-low reset
//     i_enable              0 freezes every register (step control)
//     i_flush               bubble with all fields zeroed
//     i_risk                bubble with control zeroed, data still loaded
//     i_ctrl, i_halt        control bundle and halt flag from ID
//     i_pc4, i_rs_data, i_rt_data, i_imm, i_rs, i_rt, i_rd, i_shamt, i_funct
//                           decode datapath fields
//     o_*                   registered copies of the above
//     o_valid               1 = real instruction, 0 = bubble
//     o_halt_seen           sticky: a halt has been loaded since reset
//     o_bubble_cnt          saturating count of bubbles inserted
//   Every output is a flop; nothing passes combinationally input to output.
module id_ex_stage_latch
  import id_ex_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_FUNCT = 6,
  parameter int NB_CNT   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic                i_risk,
  input  logic [NB_CTRL-1:0]  i_ctrl,
  input  logic                i_halt,
  input  logic [NB_DATA-1:0]  i_pc4,
  input  logic [NB_DATA-1:0]  i_rs_data,
  input  logic [NB_DATA-1:0]  i_rt_data,
  input  logic [NB_DATA-1:0]  i_imm,
  input  logic [NB_ADDR-1:0]  i_rs,
  input  logic [NB_ADDR-1:0]  i_rt,
  input  logic [NB_ADDR-1:0]  i_rd,
  input  logic [NB_ADDR-1:0]  i_shamt,
  input  logic [NB_FUNCT-1:0] i_funct,
  output logic [NB_CTRL-1:0]  o_ctrl,
  output logic                o_halt,
  output logic [NB_DATA-1:0]  o_pc4,
  output logic [NB_DATA-1:0]  o_rs_data,
  output logic [NB_DATA-1:0]  o_rt_data,
  output logic [NB_DATA-1:0]  o_imm,
  output logic [NB_ADDR-1:0]  o_rs,
  output logic [NB_ADDR-1:0]  o_rt,
  output logic [NB_ADDR-1:0]  o_rd,
  output logic [NB_ADDR-1:0]  o_shamt,
  output logic [NB_FUNCT-1:0] o_funct,
  output logic                o_valid,
  output logic                o_halt_seen,
  output logic [NB_CNT-1:0]   o_bubble_cnt
);

  latch_op_t op;

  // Freeze outranks flush, flush outranks stall; flush+stall is one bubble.
  always_comb begin
    op = OP_LOAD;
    if (!i_enable) begin
      op = OP_FREEZE;
    end else if (i_flush) begin
      op = OP_FLUSH;
    end else if (i_risk) begin
      op = OP_STALL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ctrl      <= '0;
      o_halt      <= 1'b0;
      o_pc4       <= '0;
      o_rs_data   <= '0;
      o_rt_data   <= '0;
      o_imm       <= '0;
      o_rs        <= '0;
      o_rt        <= '0;
      o_rd        <= '0;
      o_shamt     <= '0;
      o_funct     <= '0;
      o_valid     <= 1'b0;
      o_halt_seen <= 1'b0;
    end else begin
      case (op)
        OP_FREEZE: begin
          // hold everything
        end
        OP_FLUSH: begin
          o_ctrl    <= '0;
          o_halt    <= 1'b0;
          o_pc4     <= '0;
          o_rs_data <= '0;
          o_rt_data <= '0;
          o_imm     <= '0;
          o_rs      <= '0;
          o_rt      <= '0;
          o_rd      <= '0;
          o_shamt   <= '0;
          o_funct   <= '0;
          o_valid   <= 1'b0;
        end
        OP_STALL: begin
          // The mux has already zeroed i_ctrl; zero again so the bubble
          // does not depend on the mux being correct.
          o_ctrl    <= '0;
          o_halt    <= 1'b0;
          o_pc4     <= i_pc4;
          o_rs_data <= i_rs_data;
          o_rt_data <= i_rt_data;
          o_imm     <= i_imm;
          o_rs      <= i_rs;
          o_rt      <= i_rt;
          o_rd      <= i_rd;
          o_shamt   <= i_shamt;
          o_funct   <= i_funct;
          o_valid   <= 1'b0;
        end
        OP_LOAD: begin
          o_ctrl    <= i_ctrl;
          o_halt    <= i_halt;
          o_pc4     <= i_pc4;
          o_rs_data <= i_rs_data;
          o_rt_data <= i_rt_data;
          o_imm     <= i_imm;
          o_rs      <= i_rs;
          o_rt      <= i_rt;
          o_rd      <= i_rd;
          o_shamt   <= i_shamt;
          o_funct   <= i_funct;
          o_valid   <= 1'b1;
          if (i_halt) begin
            o_halt_seen <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .NB_CNT (NB_CNT)
  ) u_bubble_cnt (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .enable (i_enable),
    .inc    (i_flush | i_risk),
    .count  (o_bubble_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage_latch.sv
module tb_id_ex_stage_latch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        rst_n, enable, flush, risk, halt;
  logic [20:0] ctrl;
  logic [31:0] pc4, rs_data, rt_data, imm;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;

  // ---------------- DUT outputs (default and 2-bit counter builds) ----------------
  logic [20:0] q_ctrl, s_ctrl;
  logic        q_halt, s_halt, q_valid, s_valid, q_seen, s_seen;
  logic [31:0] q_pc4, q_rs_data, q_rt_data, q_imm, s_pc4, s_rs_data, s_rt_data, s_imm;
  logic [4:0]  q_rs, q_rt, q_rd, q_shamt, s_rs, s_rt, s_rd, s_shamt;
  logic [5:0]  q_funct, s_funct;
  logic [15:0] q_cnt;
  logic [1:0]  s_cnt;

  id_ex_stage_latch dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush), .i_risk(risk),
    .i_ctrl(ctrl), .i_halt(halt), .i_pc4(pc4), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_imm(imm), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
    .o_ctrl(q_ctrl), .o_halt(q_halt), .o_pc4(q_pc4), .o_rs_data(q_rs_data),
    .o_rt_data(q_rt_data), .o_imm(q_imm), .o_rs(q_rs), .o_rt(q_rt), .o_rd(q_rd),
    .o_shamt(q_shamt), .o_funct(q_funct), .o_valid(q_valid), .o_halt_seen(q_seen),
    .o_bubble_cnt(q_cnt)
  );

  id_ex_stage_latch #(.NB_CNT(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush), .i_risk(risk),
    .i_ctrl(ctrl), .i_halt(halt), .i_pc4(pc4), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_imm(imm), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
    .o_ctrl(s_ctrl), .o_halt(s_halt), .o_pc4(s_pc4), .o_rs_data(s_rs_data),
    .o_rt_data(s_rt_data), .o_imm(s_imm), .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd),
    .o_shamt(s_shamt), .o_funct(s_funct), .o_valid(s_valid), .o_halt_seen(s_seen),
    .o_bubble_cnt(s_cnt)
  );

  // ---------------- scoreboard types ----------------
  typedef struct packed {
    logic [20:0] ctrl;
    logic        halt;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic        valid;
    logic        halt_seen;
  } obs_t;

  typedef struct packed {
    obs_t        obs;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [31:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   tag_n      = 0;

  // ---------------- reference model (architectural state after each edge) ----------------
  obs_t m;
  int   m_cnt;
  int   m_cnt2;

  task automatic model_edge();
    logic hs;
    if (!rst_n) begin
      m = '0; m_cnt = 0; m_cnt2 = 0;
    end else if (enable) begin
      if (flush || risk) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3)    m_cnt2 = m_cnt2 + 1;
      end
      if (flush) begin
        hs = m.halt_seen;
        m = '0;
        m.halt_seen = hs;
      end else begin
        m.pc4 = pc4; m.rs_data = rs_data; m.rt_data = rt_data; m.imm = imm;
        m.rs = rs; m.rt = rt; m.rd = rd; m.shamt = shamt; m.funct = funct;
        if (risk) begin
          m.ctrl = '0; m.halt = 1'b0; m.valid = 1'b0;
        end else begin
          m.ctrl = ctrl; m.halt = halt; m.valid = 1'b1;
          if (halt) m.halt_seen = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    exp_t e;
    model_edge();
    e.obs  = m;
    e.cnt  = 16'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
    e.tag  = 32'(tag_n);
    tag_n++;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_data();
    ctrl = 21'($urandom); halt = 1'($urandom);
    pc4 = $urandom; rs_data = $urandom; rt_data = $urandom; imm = $urandom;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    shamt = 5'($urandom); funct = 6'($urandom);
  endtask

  task automatic zero_data();
    ctrl = '0; halt = 0; pc4 = '0; rs_data = '0; rt_data = '0; imm = '0;
    rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
  endtask

  task automatic ctl(input logic r, input logic en, input logic fl, input logic rk);
    rst_n = r; enable = en; flush = fl; risk = rk;
  endtask

  // ---------------- monitor / checker ----------------
  task automatic check_obs(input string name, input int tag, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s vec%0d: got ctrl=%h halt=%b pc4=%h rs_d=%h rt_d=%h imm=%h rs=%h rt=%h rd=%h sh=%h fn=%h v=%b seen=%b | expected ctrl=%h halt=%b pc4=%h rs_d=%h rt_d=%h imm=%h rs=%h rt=%h rd=%h sh=%h fn=%h v=%b seen=%b",
               name, tag, got.ctrl, got.halt, got.pc4, got.rs_data, got.rt_data, got.imm,
               got.rs, got.rt, got.rd, got.shamt, got.funct, got.valid, got.halt_seen,
               exp.ctrl, exp.halt, exp.pc4, exp.rs_data, exp.rt_data, exp.imm,
               exp.rs, exp.rt, exp.rd, exp.shamt, exp.funct, exp.valid, exp.halt_seen);
    end
  endtask

  initial begin
    exp_t e;
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{q_ctrl, q_halt, q_pc4, q_rs_data, q_rt_data, q_imm, q_rs, q_rt, q_rd,
              q_shamt, q_funct, q_valid, q_seen};
        check_obs("outputs", int'(e.tag), g, e.obs);
        g = '{s_ctrl, s_halt, s_pc4, s_rs_data, s_rt_data, s_imm, s_rs, s_rt, s_rd,
              s_shamt, s_funct, s_valid, s_seen};
        check_obs("outputs_cnt2", int'(e.tag), g, e.obs);
        vectors++;
        if (q_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL bubble_cnt vec%0d: got %0d expected %0d", e.tag, q_cnt, e.cnt);
        end
        vectors++;
        if (s_cnt !== e.cnt2) begin
          miscompares++;
          $display("FAIL bubble_cnt_sat vec%0d: got %0d expected %0d", e.tag, s_cnt, e.cnt2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wait_cycles;
    m = '0; m_cnt = 0; m_cnt2 = 0;
    ctl(1'b0, 1'b1, 1'b1, 1'b1);
    ctrl = '1; halt = 1; pc4 = '1; rs_data = '1; rt_data = '1; imm = '1;
    rs = '1; rt = '1; rd = '1; shamt = '1; funct = '1;
    @(negedge clk);

    // 1: reset with all inputs high
    step(); step();

    // 2: plain load
    zero_data();
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    ctrl = 21'h0A5A5; pc4 = 32'h0000_0010; imm = 32'hFFFF_FFFC; rd = 5'd9;
    step();

    // 3: freeze with new inputs and flush requested
    for (int i = 0; i < 3; i++) begin
      rand_data();
      ctl(1'b1, 1'b0, 1'b1, 1'($urandom));
      step();
    end

    // 4: flush, then stall, then both
    rand_data();
    ctl(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    rand_data();
    rs_data = 32'h1234;
    ctl(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    rand_data();
    ctl(1'b1, 1'b1, 1'b1, 1'b1);
    step();

    // 5: halt loads, then flush keeps sticky flag
    rand_data();
    halt = 1;
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    rand_data();
    ctl(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    rand_data();
    ctl(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    // reset while frozen clears everything including the sticky flag
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // 6: saturation of the 2-bit counter build (and 16-bit build counting on)
    for (int i = 0; i < 6; i++) begin
      rand_data();
      ctl(1'b1, 1'b1, 1'b0, 1'b1);
      step();
    end

    // random phase
    for (int i = 0; i < 400; i++) begin
      rand_data();
      halt = ($urandom_range(0, 7) == 0);
      ctl(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      step();
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
